// File: rtl/pwm_generator.sv
// Duty-cycle PWM with prescaled step counter, one-hot duty capture and
// double-buffered duty update applied only on period boundaries.
module pwm_generator #(
  parameter int WORD_LENGTH = 8,
  parameter int PRESCALE    = 1,
  parameter bit INVERT      = 1'b0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [WORD_LENGTH-1:0]             duty_onehot,
  input  logic                               duty_load,
  output logic                               pwm_out,
  output logic [$clog2(WORD_LENGTH+1)-1:0]   duty_level,
  output logic                               period_end,
  output logic                               load_pending
);

  localparam int LVL_W = $clog2(WORD_LENGTH + 1);
  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int ST_W  = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  logic [PS_W-1:0]  presc_q, presc_d;
  logic [ST_W-1:0]  step_q, step_d;
  logic [LVL_W-1:0] shadow_q, shadow_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             pending_q, pending_d;

  logic             tick;
  logic             boundary;
  logic [LVL_W-1:0] dec_level;

  assign tick     = enable && (presc_q == PS_W'(PRESCALE - 1));
  assign boundary = tick && (step_q == ST_W'(WORD_LENGTH - 1));

  // Highest set bit wins, so malformed one-hot input still decodes sanely.
  always_comb begin
    dec_level = '0;
    for (int unsigned i = 0; i < WORD_LENGTH; i++) begin
      if (duty_onehot[i]) dec_level = LVL_W'(i + 1);
    end
  end

  always_comb begin
    presc_d   = presc_q;
    step_d    = step_q;
    shadow_d  = shadow_q;
    level_d   = level_q;
    pending_d = pending_q;

    if (tick) begin
      presc_d = '0;
      if (step_q == ST_W'(WORD_LENGTH - 1)) step_d = '0;
      else                                  step_d = step_q + 1'b1;
    end else if (enable) begin
      presc_d = presc_q + 1'b1;
    end

    if (boundary && pending_q) begin
      level_d   = shadow_q;
      pending_d = 1'b0;
    end

    // A load coinciding with a boundary re-arms pending after the old value is applied.
    if (duty_load) begin
      shadow_d  = dec_level;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      step_q    <= '0;
      shadow_q  <= '0;
      level_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      step_q    <= step_d;
      shadow_q  <= shadow_d;
      level_q   <= level_d;
      pending_q <= pending_d;
    end
  end

  assign pwm_out      = (enable && (LVL_W'(step_q) < level_q)) ^ INVERT;
  assign duty_level   = level_q;
  assign period_end   = boundary;
  assign load_pending = pending_q;

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001: Parameter WORD_LENGTH, default 8, SHALL set the number of duty steps per PWM period and the width of the one-hot duty input.
REQ-002: Parameter PRESCALE, default 1, SHALL set the number of clk cycles per duty step (legal range 1 or greater).
REQ-003: Parameter INVERT, default 0, SHALL set the output polarity (1 = active-low PWM).
REQ-004: clk, input, 1 -- single clock; all state SHALL update on its rising edge.
REQ-005: reset, input, 1 -- asynchronous, active-high reset.
REQ-006: enable, input, 1 -- run/hold control for the PWM counters.
REQ-007: duty_onehot, input, WORD_LENGTH -- requested duty in one-hot form; bit i set means level i+1.
REQ-008: duty_load, input, 1 -- single-cycle strobe that captures duty_onehot.
REQ-009: pwm_out, output, 1 -- PWM waveform.
REQ-010: duty_level, output, $clog2(WORD_LENGTH+1) -- duty level currently in effect (0..WORD_LENGTH).
REQ-011: period_end, output, 1 -- one-cycle pulse on the last clk cycle of each period.
REQ-012: load_pending, output, 1 -- high while a captured duty waits for the next period boundary.

Function
REQ-013: The prescaler SHALL count 0..PRESCALE-1 while enable=1; tick SHALL be asserted when prescaler=PRESCALE-1 and enable=1; the prescaler SHALL wrap to 0 on tick.
REQ-014: The step counter SHALL advance by 1 on each tick, counting 0..WORD_LENGTH-1, and SHALL wrap to 0 after WORD_LENGTH-1.
REQ-015: A period boundary SHALL be the tick on which step=WORD_LENGTH-1; period_end SHALL be 1 in exactly that cycle and 0 in all other cycles.
REQ-016: The duty decode SHALL be a priority encode: level = (index of the highest set bit of duty_onehot) + 1; all-zero SHALL decode to 0; a non-one-hot value SHALL decode by its highest set bit.
REQ-017: On duty_load=1, the decoded level SHALL be written to a shadow register and load_pending SHALL be set to 1 on the next edge.
REQ-018: On a period boundary with load_pending=1, duty_level SHALL take the shadow value and load_pending SHALL clear on the same edge.
REQ-019: If duty_load=1 coincides with a period boundary, the new value SHALL go to the shadow, load_pending SHALL stay 1, and the previously pending value (if any) SHALL be applied at this boundary.
REQ-020: If more than one duty_load occurs before a boundary, the last load SHALL win.
REQ-021: pwm_out SHALL equal (step < duty_level) XOR INVERT, decoded from registered state only, so that it is glitch-free.
REQ-022: duty_level=0 SHALL give a constant inactive output; duty_level=WORD_LENGTH SHALL give a constant active output with no single-step pulses.
REQ-023: With enable=0, the prescaler, step counter and duty_level SHALL hold, and pwm_out SHALL be forced to INVERT (inactive); duty_load SHALL still be accepted into the shadow.
REQ-024: When enable returns to 1, counting SHALL resume from the held step and prescaler values.

Reset
REQ-025: When reset=1, the block SHALL immediately, without waiting for clk, set prescaler=0, step=0, shadow=0, duty_level=0, load_pending=0, period_end=0 and pwm_out=INVERT.
REQ-026: A reset asserted mid-period SHALL discard any pending load; after reset deasserts, the first period SHALL start at step 0 on the next enabled edge.

Verification (WORD_LENGTH=8, INVERT=0, PRESCALE=1 unless stated otherwise)
REQ-027: Apply reset, then enable=1 and load 8'b00001000 -> load_pending=1 until the first period_end; then duty_level=4 and pwm_out repeats 4 high / 4 low, with period_end every 8 cycles.
REQ-028: Load 8'b00000000 -> pwm_out is constantly 0. Load 8'b10000000 -> duty_level=8 and pwm_out is constantly 1.
REQ-029: Load the non-one-hot value 8'b00100101 -> duty_level=6 after the next boundary.
REQ-030: With duty_level=2, load 8'b01000000 at step 3 -> the current period stays at 2 high cycles; the next period (from step 0) has 7 high cycles.
REQ-031: Assert reset asynchronously at step 5 with load_pending=1 -> all outputs go to reset values before the next clk edge, and the pending load is lost.
REQ-032: With PRESCALE=3 and duty 8'b00000100 -> each step lasts 3 cycles, the period is 24 cycles with 9 high, and enable=0 for 5 cycles stretches exactly one period by 5 cycles with pwm_out=0 during the hold.
